full_adder_core: RTL and testbench
==================================

# full_adder_core

Parameterizable ripple-carry full adder with a zero-latency combinational result and a one-cycle registered copy of that result. With `WIDTH=1` the combinational path is the classic 1-bit full adder: sum = a^b^cin, cout = majority(a,b,cin). It is the arithmetic leaf for datapaths needing either a direct or a registered add with carry in and carry out.

## Interface
- `WIDTH`, default 1: operand and sum width in bits. Legal range is 1 to 64.
- `clk`  input  1  the block's single clock. Rising edge active.
- `rst`  input  1  reset, asynchronous and active-high.
- `a`  input  WIDTH  operand A, unsigned (or two's complement for `ovf`).
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry in.
- `in_valid`  input  1  qualifies `a`/`b`/`cin` for capture into the register stage.
- `sum`  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH.
- `cout`  output  1  combinational carry out, bit WIDTH of a+b+cin.
- `sum_q`  output  WIDTH  registered `sum`.
- `cout_q`  output  1  registered `cout`.
- `out_valid`  output  1  `sum_q`/`cout_q` hold a captured result.
- `ovf`, `ovf_q`  output  1 each  signed overflow, combinational and registered. These ports exist only with `FULL_ADDER_CORE_OVF_EN`.

## Operation
- The ripple chain is built from WIDTH cells. Cell i computes:
  - s[i] = a[i]^b[i]^c[i]
  - c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]
  - c[0] = cin and cout = c[WIDTH].
- `sum`/`cout` are purely combinational. They do not depend on `clk`, `rst`, or `in_valid`.
- Register stage, on a rising `clk` edge:
  - If `in_valid`=1: `sum_q`<=`sum`, `cout_q`<=`cout`, `out_valid`<=1.
  - If `in_valid`=0: `sum_q`/`cout_q` hold their values and `out_valid`<=0.
- Arithmetic is exact with no saturation. {cout,sum} always equals a+b+cin in WIDTH+1 bits.
- Boundary cases:
  - All-ones + 0 + cin=1 wraps `sum` to 0 with `cout`=1.
  - 0+0+0 gives 0 with `cout`=0.
  - X/Z on inputs is not handled specially.

## Timing
- Combinational latency is zero clock cycles. `sum`/`cout` settle within one propagation delay of any input change.
- Registered latency is one cycle, from `in_valid` sampled high at edge N to `sum_q`/`cout_q`/`out_valid` updated after edge N.
- Throughput is one result per cycle, with no backpressure.
- Reset behaviour:
  - `rst`=1 immediately forces `sum_q`=0, `cout_q`=0, `out_valid`=0 (and `ovf_q`=0), regardless of `clk`.
  - Reset mid-stream discards the pending result. The first capture after release occurs at the first rising edge with `rst`=0 and `in_valid`=1.
  - Combinational outputs stay live during reset.

## Configuration
- Macro `FULL_ADDER_CORE_OVF_EN` controls the signed-overflow feature.
- Defined:
  - `ovf` = c[WIDTH]^c[WIDTH-1], the two's-complement overflow.
  - For WIDTH=1, ovf = cout^cin.
  - `ovf_q` registers `ovf` under the same `in_valid` and reset rules as `sum_q`.
- Undefined: `ovf`/`ovf_q` ports and logic are absent. All other behaviour is identical.

## Structure
- Package `full_adder_pkg` holds:
  - `FA_WIDTH_DEFAULT`=1 and `FA_WIDTH_MAX`=64.
  - A function computing the reference {cout,sum} for benches.
- Sub-module `fa_cell` is the 1-bit gate-level full adder (a, b, cin -> sum, cout). The top instantiates WIDTH of them in a generate loop.
- Register stage and overflow logic live in the top.

## Test plan
- WIDTH=1, all 8 combinations of {a,b,cin}, 10 ns apart, must give:
  - 000→sum0 cout0; 001→1,0; 010→1,0; 011→0,1
  - 100→1,0; 101→0,1; 110→0,1; 111→1,1
- WIDTH=8, a=8'hFF, b=8'h00, cin=1 -> `sum`=8'h00, `cout`=1. With `in_valid`=1 at the next edge -> `sum_q`=8'h00, `cout_q`=1, `out_valid`=1.
- WIDTH=8, a=8'h7F, b=8'h01, cin=0 with the macro defined -> `sum`=8'h80, `cout`=0, `ovf`=1. For a=8'h80, b=8'h80 -> `sum`=8'h00, `cout`=1, `ovf`=1.
- Assert `rst` asynchronously between clock edges while `out_valid`=1 -> `sum_q`=0, `cout_q`=0, `out_valid`=0 immediately, while `sum` still tracks the inputs.
- `in_valid` pattern 1,0,1 over three cycles with distinct operands -> `out_valid` follows 1,0,1 one cycle later, and `sum_q` holds its value during the gap cycle.
- Randomized WIDTH=16 run, 1000 vectors -> {cout,sum} equals the package reference function every cycle.

Source files
------------

// File: rtl/full_adder_core_pkg.sv
// Shared constants and a reference add for full_adder_core.
// The optional signed-overflow ports are enabled by FULL_ADDER_CORE_OVF_EN.
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX     = 64;

  // Golden {cout,sum}: operands must already fit in `width` bits, so bit
  // `width` of the result is the carry out and every higher bit is zero.
  function automatic logic [FA_WIDTH_MAX:0] fa_ref(
    input logic [FA_WIDTH_MAX-1:0] a,
    input logic [FA_WIDTH_MAX-1:0] b,
    input logic                    cin
  );
    logic [FA_WIDTH_MAX:0] full;
    full = {1'b0, a} + {1'b0, b} + {{FA_WIDTH_MAX{1'b0}}, cin};
    return full;
  endfunction

endpackage

// File: rtl/full_adder_core_if.sv
// Operand/result bundle for full_adder_core; master drives operands, slave is the adder.
// ovf/ovf_q exist only under FULL_ADDER_CORE_OVF_EN.
interface full_adder_core_if
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid;
`ifdef FULL_ADDER_CORE_OVF_EN
  logic             ovf;
  logic             ovf_q;
`endif

  modport master (
    output a, b, cin, in_valid,
    input  sum, cout, sum_q, cout_q, out_valid
`ifdef FULL_ADDER_CORE_OVF_EN
    , input ovf, ovf_q
`endif
  );

  modport slave (
    input  a, b, cin, in_valid,
    output sum, cout, sum_q, cout_q, out_valid
`ifdef FULL_ADDER_CORE_OVF_EN
    , output ovf, ovf_q
`endif
  );

endinterface

// File: rtl/full_adder_core_cell.sv
// fa_cell: 1-bit gate-level full adder, the leaf of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder_core.sv
// Ripple-carry adder with a live combinational result and a one-cycle registered copy.
// FULL_ADDER_CORE_OVF_EN adds combinational/registered two's-complement overflow.
module full_adder_core
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  full_adder_core_if.slave io
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = io.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (io.a[i]),
      .b    (io.b[i]),
      .cin  (c[i]),
      .sum  (s[i]),
      .cout (c[i+1])
    );
  end

  assign io.sum  = s;
  assign io.cout = c[WIDTH];

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             vld_d, vld_q;
`ifdef FULL_ADDER_CORE_OVF_EN
  logic             ovf;
  logic             ovf_d, ovf_q;

  // Carry into and out of the sign bit disagree exactly on signed overflow.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  // Result registers hold when idle; only the valid flag drops.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = io.in_valid;
`ifdef FULL_ADDER_CORE_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (io.in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
`ifdef FULL_ADDER_CORE_OVF_EN
      ovf_d  = ovf;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
`ifdef FULL_ADDER_CORE_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
`ifdef FULL_ADDER_CORE_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign io.sum_q     = sum_q;
  assign io.cout_q    = cout_q;
  assign io.out_valid = vld_q;
`ifdef FULL_ADDER_CORE_OVF_EN
  assign io.ovf       = ovf;
  assign io.ovf_q     = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Directed and random checks of full_adder_core at WIDTH 1, 8 and 16.
module tb_full_adder_core;
  import full_adder_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  full_adder_core_if #(.WIDTH(1))  if1 ();
  full_adder_core_if #(.WIDTH(8))  if8 ();
  full_adder_core_if #(.WIDTH(16)) if16 ();

  full_adder_core #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .io(if1));
  full_adder_core #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .io(if8));
  full_adder_core #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .io(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0]  tbl_sum;
    logic [7:0]  tbl_cout;
    logic [2:0]  v;
    logic [64:0] r;
    logic [16:0] exp_q;
    logic        iv;

    n_chk = 0;
    n_err = 0;
    tbl_sum  = 8'b1001_0110;
    tbl_cout = 8'b1110_1000;

    rst = 1'b1;
    if1.a = '0;  if1.b = '0;  if1.cin = 1'b0;  if1.in_valid = 1'b0;
    if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;  if8.in_valid = 1'b0;
    if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.in_valid = 1'b0;
    #1;
    chk("rst_vld8",   65'(if8.out_valid), 65'd0);
    chk("rst_sumq8",  65'(if8.sum_q),     65'd0);
    chk("rst_coutq8", 65'(if8.cout_q),    65'd0);
    chk("rst_vld16",  65'(if16.out_valid), 65'd0);
    chk("rst_sumq1",  65'(if1.sum_q),     65'd0);
    #11;
    rst = 1'b0;

    // 1-bit truth table, 10 ns per vector
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if1.a = v[2]; if1.b = v[1]; if1.cin = v[0];
      #10;
      chk($sformatf("tt_sum_%0d", i),  65'(if1.sum),  65'(tbl_sum[i]));
      chk($sformatf("tt_cout_%0d", i), 65'(if1.cout), 65'(tbl_cout[i]));
    end

    // wrap: FF + 00 + 1
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'h00; if8.cin = 1'b1; if8.in_valid = 1'b1;
    #1;
    chk("wrap_sum",  65'(if8.sum),  65'h00);
    chk("wrap_cout", 65'(if8.cout), 65'd1);
    @(posedge clk); #1;
    chk("wrap_sumq",  65'(if8.sum_q),     65'h00);
    chk("wrap_coutq", 65'(if8.cout_q),    65'd1);
    chk("wrap_vld",   65'(if8.out_valid), 65'd1);

    // asynchronous reset between edges; comb path stays live
    #2;
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_sumq",  65'(if8.sum_q),     65'd0);
    chk("arst_coutq", 65'(if8.cout_q),    65'd0);
    chk("arst_vld",   65'(if8.out_valid), 65'd0);
    chk("arst_sum",   65'(if8.sum),       65'h46);
    chk("arst_cout",  65'(if8.cout),      65'd0);
    if8.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // zero + zero
    if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
    #1;
    chk("zero_sum",  65'(if8.sum),  65'd0);
    chk("zero_cout", 65'(if8.cout), 65'd0);

    // in_valid 1,0,1
    @(negedge clk);
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("p1_vld",  65'(if8.out_valid), 65'd1);
    chk("p1_sumq", 65'(if8.sum_q),     65'h30);
    @(negedge clk);
    if8.a = 8'h01; if8.b = 8'h02; if8.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("p2_vld",   65'(if8.out_valid), 65'd0);
    chk("p2_sumq",  65'(if8.sum_q),     65'h30);
    chk("p2_coutq", 65'(if8.cout_q),    65'd0);
    @(negedge clk);
    if8.a = 8'hF0; if8.b = 8'h20; if8.cin = 1'b1; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("p3_vld",   65'(if8.out_valid), 65'd1);
    chk("p3_sumq",  65'(if8.sum_q),     65'h11);
    chk("p3_coutq", 65'(if8.cout_q),    65'd1);

`ifdef FULL_ADDER_CORE_OVF_EN
    @(negedge clk);
    if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0; if8.in_valid = 1'b1;
    #1;
    chk("ovf1_sum",  65'(if8.sum),  65'h80);
    chk("ovf1_cout", 65'(if8.cout), 65'd0);
    chk("ovf1_ovf",  65'(if8.ovf),  65'd1);
    @(posedge clk); #1;
    chk("ovf1_ovfq", 65'(if8.ovf_q), 65'd1);
    @(negedge clk);
    if8.a = 8'h80; if8.b = 8'h80; if8.in_valid = 1'b0;
    #1;
    chk("ovf2_sum",  65'(if8.sum),  65'h00);
    chk("ovf2_cout", 65'(if8.cout), 65'd1);
    chk("ovf2_ovf",  65'(if8.ovf),  65'd1);
    if8.a = 8'h01; if8.b = 8'h01;
    #1;
    chk("ovf3_ovf", 65'(if8.ovf), 65'd0);
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b0;
    #1;
    chk("ovf_w1", 65'(if1.ovf), 65'd1);
`endif

    // random 16-bit run against the package reference
    exp_q = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if16.a   = 16'($urandom());
      if16.b   = 16'($urandom());
      if16.cin = 1'($urandom_range(0, 1));
      iv       = 1'($urandom_range(0, 1));
      if16.in_valid = iv;
      #1;
      r = fa_ref(64'(if16.a), 64'(if16.b), if16.cin);
      chk("rnd_comb", 65'({if16.cout, if16.sum}), 65'(r[16:0]));
      @(posedge clk); #1;
      if (iv) exp_q = r[16:0];
      chk("rnd_vld", 65'(if16.out_valid), 65'(iv));
      chk("rnd_reg", 65'({if16.cout_q, if16.sum_q}), 65'(exp_q));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
